// File: rtl/map_bank_ctl.sv
// Bank mapper for SSF-style cartridges: BANKS CPU windows remapped through /TIME-area registers.
// Optional save-state register access is compiled in with `define MAP_BANK_SST_EN.

module map_bank_reg #(
    parameter int                BANK_W  = 5,
    parameter logic [BANK_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [BANK_W-1:0] wr_data,
    output logic [BANK_W-1:0] bank
);

    logic [BANK_W-1:0] bank_q, bank_d;

    always_comb begin
        bank_d = bank_q;
        if (wr_en) bank_d = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bank_q <= RST_VAL;
        else        bank_q <= bank_d;
    end

    assign bank = bank_q;

endmodule

module map_bank_ctl #(
    parameter int         BANKS     = 8,
    parameter int         BANK_W    = 5,
    parameter int         PAGE_AW   = 19,
    parameter logic [7:0] REG_BASE  = 8'hF0,
    parameter int         BRAM_PAGE = 31
) (
    input  logic                      clk,
    input  logic                      map_rst_n,
    input  logic [23:0]               cpu_addr,
    input  logic [15:0]               cpu_data,
    input  logic                      reg_ce,
    input  logic                      reg_we,
    input  logic                      sst_act,
    input  logic                      sst_we,
    input  logic [7:0]                sst_addr,
    input  logic [7:0]                sst_di,
    output logic [7:0]                sst_do,
    output logic [PAGE_AW+BANK_W-1:0] phys_addr,
    output logic [1:0]                mem_sel,
    output logic                      cart,
    output logic                      led_r,
    output logic                      wr_on,
    output logic                      lock
);

    localparam int IDX_W = $clog2(BANKS);

    logic [BANKS-1:0][BANK_W-1:0] bank;
    logic [BANKS-1:0][BANK_W-1:0] bank_wd;
    logic [BANKS-1:0]             bank_we;
    logic [3:0]                   ctrl_q, ctrl_d;
    logic [2:0]                   sync_q, sync_d;
    logic [7:0]                   reg_off;
    logic                         hit;
    logic                         wr_pulse;
    logic [IDX_W-1:0]             idx;
    logic [IDX_W-1:0]             win;
    logic [BANK_W-1:0]            page;
    logic [BANK_W-1:0]            sst_bank_wd;
    logic                         sst_on;
    logic                         sst_wr;
    logic                         port_unused;

    // hit is asynchronous to clk; two sync stages plus one history stage for edge detect
    assign reg_off  = {cpu_addr[7:1], 1'b0} & ~8'(2*BANKS-1);
    assign hit      = reg_ce & reg_we & (reg_off == REG_BASE);
    assign sync_d   = {sync_q[1:0], hit};
    assign wr_pulse = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) sync_q <= '0;
        else            sync_q <= sync_d;
    end

    assign idx = cpu_addr[IDX_W:1];
    assign win = cpu_addr[PAGE_AW +: IDX_W];

`ifdef MAP_BANK_SST_EN
    assign sst_on = sst_act;
    assign sst_wr = sst_act & sst_we;
`else
    assign sst_on = 1'b0;
    assign sst_wr = 1'b0;
`endif
    assign sst_bank_wd = BANK_W'(sst_di);

    // save-state owns the registers while active; CPU pulses in that window are dropped
    always_comb begin
        bank_we = '0;
        bank_wd = '0;
        ctrl_d  = ctrl_q;
        if (sst_on) begin
            for (int i = 0; i < BANKS; i++) begin
                if (sst_wr && sst_addr == 8'(i)) begin
                    bank_we[i] = 1'b1;
                    bank_wd[i] = sst_bank_wd;
                end
            end
            if (sst_wr && sst_addr == 8'(BANKS)) ctrl_d = sst_di[3:0];
        end else if (wr_pulse) begin
            if (idx == '0) begin
                if (cpu_data[15]) begin
                    bank_we[0] = 1'b1;
                    bank_wd[0] = cpu_data[BANK_W-1:0];
                    ctrl_d     = cpu_data[14:11];
                end
            end else if (!ctrl_q[3]) begin
                bank_we[idx] = 1'b1;
                bank_wd[idx] = cpu_data[BANK_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) ctrl_q <= 4'h0;
        else            ctrl_q <= ctrl_d;
    end

    for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
        map_bank_reg #(
            .BANK_W (BANK_W),
            .RST_VAL(BANK_W'(gi))
        ) u_bank (
            .clk    (clk),
            .rst_n  (map_rst_n),
            .wr_en  (bank_we[gi]),
            .wr_data(bank_wd[gi]),
            .bank   (bank[gi])
        );
    end

    assign page      = bank[win];
    assign phys_addr = {page, cpu_addr[PAGE_AW-1:0]};

    always_comb begin
        mem_sel = 2'd1;
        if (!page[BANK_W-1])              mem_sel = 2'd0;
        else if (int'(page) >= BRAM_PAGE) mem_sel = 2'd2;
    end

`ifdef MAP_BANK_SST_EN
    always_comb begin
        sst_do = 8'hFF;
        if (sst_addr < 8'(BANKS))       sst_do = 8'(bank[sst_addr[IDX_W-1:0]]);
        else if (sst_addr == 8'(BANKS)) sst_do = {4'h0, ctrl_q};
    end
`else
    assign sst_do = 8'hFF;
`endif

    assign cart  = ctrl_q[0];
    assign led_r = ctrl_q[1];
    assign wr_on = ctrl_q[2];
    assign lock  = ctrl_q[3];

    // address/data bits outside the decoded fields are intentionally ignored
    assign port_unused = ^{cpu_addr, cpu_data, sst_act, sst_we, sst_addr, sst_di};

endmodule

// File: tb/tb_map_bank_ctl.sv
// Randomized self-checking bench for map_bank_ctl against a register-level reference model.
// Save-state checks follow `define MAP_BANK_SST_EN the same way as the design.

module tb_map_bank_ctl;

    logic        clk = 1'b0;
    logic        map_rst_n;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_data;
    logic        reg_ce, reg_we;
    logic        sst_act, sst_we;
    logic [7:0]  sst_addr, sst_di, sst_do;
    logic [23:0] phys_addr;
    logic [1:0]  mem_sel;
    logic        cart, led_r, wr_on, lock;

    int checks = 0;
    int errors = 0;

    int mb[8];
    int mc;

    map_bank_ctl dut (
        .clk(clk), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .reg_ce(reg_ce), .reg_we(reg_we), .sst_act(sst_act), .sst_we(sst_we),
        .sst_addr(sst_addr), .sst_di(sst_di), .sst_do(sst_do), .phys_addr(phys_addr),
        .mem_sel(mem_sel), .cart(cart), .led_r(led_r), .wr_on(wr_on), .lock(lock)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) mb[i] = i;
        mc = 0;
    endfunction

    function automatic void model_write(int idx, int d);
        if (idx == 0) begin
            if ((d / 32768) % 2 == 1) begin
                mb[0] = d % 32;
                mc    = (d / 2048) % 16;
            end
        end else if (mc < 8) begin
            mb[idx] = d % 32;
        end
    endfunction

    function automatic logic [23:0] exp_phys(logic [23:0] a);
        int w;
        w = (int'(a) / 524288) % 8;
        return 24'(mb[w] * 524288 + int'(a) % 524288);
    endfunction

    function automatic logic [1:0] exp_sel(logic [23:0] a);
        int p;
        p = mb[(int'(a) / 524288) % 8];
        if (p < 16) return 2'd0;
        if (p >= 31) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic [23:0] win_addr(int w);
        return 24'(w * 524288 + $urandom_range(0, 524287));
    endfunction

    task automatic cpu_write(int idx, logic [15:0] d, int hold, bit is_hit);
        @(negedge clk);
        cpu_addr = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    (is_hit ? 4'hF : 4'hE), 3'(idx), 1'($urandom_range(0, 1))};
        cpu_data = d;
        reg_ce   = 1'b1;
        reg_we   = 1'b1;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        reg_ce = 1'b0;
        reg_we = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk);
        cpu_addr = 24'h280000;
        #1;
        checks++;
        if (phys_addr !== 24'h280000 || mem_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_win5 phys=%h sel=%0d required phys=280000 sel=0", phys_addr, mem_sel);
        end
        checks++;
        if ({lock, wr_on, led_r, cart} !== 4'h0) begin
            errors++;
            $display("FAIL reset_ctrl got=%h required=0", {lock, wr_on, led_r, cart});
        end
        for (int w = 0; w < 8; w++) begin
            cpu_addr = win_addr(w);
            #1;
            checks++;
            if (phys_addr !== exp_phys(cpu_addr)) begin
                errors++;
                $display("FAIL reset_bank%0d phys=%h required=%h", w, phys_addr, exp_phys(cpu_addr));
            end
        end
    endtask

    task automatic test_strobe();
        cpu_write(3, 16'h0012, 20, 1'b1);
        model_write(3, 16'h0012);
        repeat (2) @(negedge clk);
        cpu_addr = 24'h180000;
        #1;
        checks++;
        if (phys_addr !== 24'h900000 || mem_sel !== 2'd1) begin
            errors++;
            $display("FAIL strobe_long phys=%h sel=%0d required phys=900000 sel=1", phys_addr, mem_sel);
        end
        // strobe held exactly three edges: the update must already be visible when it drops
        cpu_write(5, 16'h001F, 3, 1'b1);
        model_write(5, 16'h001F);
        cpu_addr = 24'h280000;
        #1;
        checks++;
        if (phys_addr !== 24'hF80000 || mem_sel !== 2'd2) begin
            errors++;
            $display("FAIL strobe_latency phys=%h sel=%0d required phys=f80000 sel=2", phys_addr, mem_sel);
        end
    endtask

    task automatic test_ctrl();
        cpu_write(0, 16'h9C05, 4, 1'b1);
        model_write(0, 16'h9C05);
        cpu_write(0, 16'h1C07, 4, 1'b1);
        model_write(0, 16'h1C07);
        @(negedge clk);
        cpu_addr = 24'h000100;
        #1;
        checks++;
        if (phys_addr !== 24'h280100 || {lock, wr_on, led_r, cart} !== 4'h3) begin
            errors++;
            $display("FAIL ctrl_write phys=%h ctrl=%h required phys=280100 ctrl=3",
                     phys_addr, {lock, wr_on, led_r, cart});
        end
    endtask

    task automatic test_lock();
        cpu_write(0, 16'hC000, 4, 1'b1);
        model_write(0, 16'hC000);
        cpu_write(2, 16'h0009, 4, 1'b1);
        model_write(2, 16'h0009);
        @(negedge clk);
        cpu_addr = 24'h100000;
        #1;
        checks++;
        if (phys_addr !== 24'h100000 || lock !== 1'b1) begin
            errors++;
            $display("FAIL lock_drop phys=%h lock=%b required phys=100000 lock=1", phys_addr, lock);
        end
        cpu_write(0, 16'h8000, 4, 1'b1);
        model_write(0, 16'h8000);
        cpu_write(2, 16'h0009, 4, 1'b1);
        model_write(2, 16'h0009);
        @(negedge clk);
        cpu_addr = 24'h100000;
        #1;
        checks++;
        if (phys_addr !== 24'h480000 || lock !== 1'b0) begin
            errors++;
            $display("FAIL lock_clear phys=%h lock=%b required phys=480000 lock=0", phys_addr, lock);
        end
    endtask

    task automatic test_sst();
        @(negedge clk);
        sst_act  = 1'b1;
        sst_addr = 8'd4;
        sst_di   = 8'h1F;
        sst_we   = 1'b1;
        @(negedge clk);
        sst_we = 1'b0;
`ifdef MAP_BANK_SST_EN
        mb[4] = 31;
`endif
        // CPU strobe while save-state holds the bus
        cpu_write(6, 16'h0011, 5, 1'b1);
        repeat (2) @(negedge clk);
`ifndef MAP_BANK_SST_EN
        model_write(6, 16'h0011);
`endif
        for (int w = 4; w < 7; w++) begin
            cpu_addr = win_addr(w);
            #1;
            checks++;
            if (phys_addr !== exp_phys(cpu_addr) || mem_sel !== exp_sel(cpu_addr)) begin
                errors++;
                $display("FAIL sst_win%0d phys=%h sel=%0d required phys=%h sel=%0d",
                         w, phys_addr, mem_sel, exp_phys(cpu_addr), exp_sel(cpu_addr));
            end
        end
        for (int a = 3; a < 11; a++) begin
            logic [7:0] want;
`ifdef MAP_BANK_SST_EN
            want = (a < 8) ? 8'(mb[a]) : (a == 8) ? 8'(mc) : 8'hFF;
`else
            want = 8'hFF;
`endif
            sst_addr = 8'(a);
            #1;
            checks++;
            if (sst_do !== want) begin
                errors++;
                $display("FAIL sst_read%0d got=%h required=%h", a, sst_do, want);
            end
        end
        @(negedge clk);
        sst_act = 1'b0;
    endtask

    task automatic test_reset_mid();
        cpu_write(1, 16'h0019, 4, 1'b1);
        model_write(1, 16'h0019);
        @(negedge clk);
        cpu_addr = 24'h0000F4;
        cpu_data = 16'h001A;
        reg_ce   = 1'b1;
        reg_we   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        map_rst_n = 1'b0;
        reg_ce    = 1'b0;
        reg_we    = 1'b0;
        repeat (2) @(negedge clk);
        map_rst_n = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        for (int w = 0; w < 8; w++) begin
            cpu_addr = win_addr(w);
            #1;
            checks++;
            if (phys_addr !== exp_phys(cpu_addr)) begin
                errors++;
                $display("FAIL rst_mid_bank%0d phys=%h required=%h", w, phys_addr, exp_phys(cpu_addr));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int          idx;
            logic [15:0] d;
            bit          h;
            idx = $urandom_range(0, 7);
            d   = 16'($urandom);
            if (idx == 0 && $urandom_range(0, 2) == 0) d[14] = 1'b0;
            h = ($urandom_range(0, 3) != 0);
            cpu_write(idx, d, $urandom_range(3, 7), h);
            if (h) model_write(idx, int'(d));
            repeat (2) @(negedge clk);
            cpu_addr = win_addr($urandom_range(0, 7));
            #1;
            checks++;
            if (phys_addr !== exp_phys(cpu_addr) || mem_sel !== exp_sel(cpu_addr)) begin
                errors++;
                $display("FAIL random%0d addr=%h phys=%h sel=%0d required phys=%h sel=%0d",
                         n, cpu_addr, phys_addr, mem_sel, exp_phys(cpu_addr), exp_sel(cpu_addr));
            end
            checks++;
            if ({lock, wr_on, led_r, cart} !== 4'(mc)) begin
                errors++;
                $display("FAIL random_ctrl%0d got=%h required=%h", n, {lock, wr_on, led_r, cart}, 4'(mc));
            end
        end
    endtask

    initial begin
        map_rst_n = 1'b0;
        cpu_addr  = '0;
        cpu_data  = '0;
        reg_ce    = 1'b0;
        reg_we    = 1'b0;
        sst_act   = 1'b0;
        sst_we    = 1'b0;
        sst_addr  = '0;
        sst_di    = '0;
        repeat (3) @(negedge clk);
        map_rst_n = 1'b1;
        test_reset();
        test_strobe();
        test_ctrl();
        test_lock();
        test_sst();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
